// File: rtl/uart_pkg.sv
// Shared UART definitions: standard baud rates and the fractional divisor helper.
package uart_pkg;

  localparam int unsigned BAUD_9600_RATE   = 9600;
  localparam int unsigned BAUD_19200_RATE  = 19200;
  localparam int unsigned BAUD_38400_RATE  = 38400;
  localparam int unsigned BAUD_57600_RATE  = 57600;
  localparam int unsigned BAUD_115200_RATE = 115200;
  localparam int unsigned BAUD_230400_RATE = 230400;
  localparam int unsigned BAUD_460800_RATE = 460800;
  localparam int unsigned BAUD_921600_RATE = 921600;

  typedef struct packed {
    logic [31:0] div_int;
    logic [31:0] div_frac;
  } baud_div_t;

  // D = clk * 2^fracw / (baud * osr), truncated, split into integer and fraction.
  function automatic baud_div_t calc_baud_div(input longint unsigned clk,
                                              input longint unsigned baud,
                                              input longint unsigned osr,
                                              input int unsigned     fracw);
    longint unsigned d;
    baud_div_t       r;
    d          = (clk << fracw) / (baud * osr);
    r.div_int  = 32'(d >> fracw);
    r.div_frac = 32'(d & ((64'd1 << fracw) - 64'd1));
    return r;
  endfunction

endpackage

// File: rtl/baud_frac_div.sv
// Fractional cycle divider: each period is div_int_eff or div_int_eff+1 cycles,
// chosen by the carry out of a phase accumulator.
module baud_frac_div
  import uart_pkg::*;
#(
  parameter int unsigned IntWidth  = 16,
  parameter int unsigned FracWidth = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 enable,
  input  logic                 clear,
  input  logic [IntWidth-1:0]  div_int_eff,
  input  logic [FracWidth-1:0] div_frac,
  output logic                 os_tick
);

  logic [IntWidth:0]  cnt;
  logic [IntWidth:0]  last;
  logic [FracWidth-1:0] acc;
  logic [FracWidth:0] sum;

  assign sum  = {1'b0, acc} + {1'b0, div_frac};
  // One extra bit so div_int_eff + carry never wraps.
  assign last = {1'b0, div_int_eff} + {{IntWidth{1'b0}}, sum[FracWidth]}
              - {{IntWidth{1'b0}}, 1'b1};

  assign os_tick = enable && !clear && !rst_i && (cnt == last);

  always_ff @(posedge clk_i) begin
    if (rst_i || clear || !enable) begin
      cnt <= '0;
      acc <= '0;
    end else if (os_tick) begin
      cnt <= '0;
      acc <= sum[FracWidth-1:0];
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/baud_gen_frac.sv
// UART baud generator: shadowed fractional divisor applied only when the line is idle,
// oversample tick from the fractional divider, bit tick every OverSampleRate ticks.
module baud_gen_frac
  import uart_pkg::*;
#(
  parameter int unsigned ClockFrequency = 50_000_000,
  parameter int unsigned OverSampleRate = 16,
  parameter int unsigned DefaultBaud    = 115_200,
  parameter int unsigned IntWidth       = 16,
  parameter int unsigned FracWidth      = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 enable_i,
  input  logic                 div_wr_i,
  input  logic [IntWidth-1:0]  div_int_i,
  input  logic [FracWidth-1:0] div_frac_i,
  input  logic                 rx_busy_i,
  input  logic                 tx_busy_i,
  output logic                 os_tick_o,
  output logic                 bit_tick_o,
  output logic                 div_pending_o,
  output logic [IntWidth-1:0]  div_int_o,
  output logic [FracWidth-1:0] div_frac_o
);

  localparam baud_div_t RstDiv = calc_baud_div(64'(ClockFrequency), 64'(DefaultBaud),
                                               64'(OverSampleRate), FracWidth);
  localparam logic [IntWidth-1:0]  RST_INT  = RstDiv.div_int[IntWidth-1:0];
  localparam logic [FracWidth-1:0] RST_FRAC = RstDiv.div_frac[FracWidth-1:0];
  localparam int unsigned          OsW      = $clog2(OverSampleRate);
  localparam logic [OsW-1:0]       OS_LAST  = OsW'(OverSampleRate - 1);

  logic [IntWidth-1:0]  act_int, shd_int, int_eff;
  logic [FracWidth-1:0] act_frac, shd_frac;
  logic                 pending, apply, os_tick;
  logic [OsW-1:0]       os_cnt;

  // A write in the same cycle wins; the apply waits for the next idle cycle.
  assign apply   = pending && !div_wr_i && !(rx_busy_i || tx_busy_i);
  assign int_eff = (act_int < IntWidth'(2)) ? IntWidth'(2) : act_int;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shd_int  <= RST_INT;
      shd_frac <= RST_FRAC;
      act_int  <= RST_INT;
      act_frac <= RST_FRAC;
      pending  <= 1'b0;
    end else if (div_wr_i) begin
      shd_int  <= div_int_i;
      shd_frac <= div_frac_i;
      pending  <= 1'b1;
    end else if (apply) begin
      act_int  <= shd_int;
      act_frac <= shd_frac;
      pending  <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || !enable_i || apply) begin
      os_cnt <= '0;
    end else if (os_tick) begin
      os_cnt <= (os_cnt == OS_LAST) ? '0 : os_cnt + 1'b1;
    end
  end

  baud_frac_div #(
    .IntWidth (IntWidth),
    .FracWidth(FracWidth)
  ) u_div (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .enable     (enable_i),
    .clear      (apply),
    .div_int_eff(int_eff),
    .div_frac   (act_frac),
    .os_tick    (os_tick)
  );

  assign os_tick_o     = os_tick;
  assign bit_tick_o    = os_tick && (os_cnt == OS_LAST);
  assign div_pending_o = pending;
  assign div_int_o     = act_int;
  assign div_frac_o    = act_frac;

endmodule
